data_req_issue: RTL and testbench

- Initiator side of the data-memory interface; sits between the EXE stage and the data SRAM-like bus.
- Turns EXE load/store requests into a single bus transaction: req/addr/size/wstrb/wdata, then waits for addr_ok and data_ok.
- Returns the raw read word to the MEM stage, which performs the load byte/half/lwl/lwr extraction.
- Detects misaligned addresses, absorbs responses for transactions cancelled by a flush, and allows one outstanding transaction.

---
 rtl/mem_if_pkg.sv | 32 +++
 rtl/store_fmt.sv | 56 +++++
 rtl/data_req_issue.sv | 186 ++++++++++++++++++
 tb/tb_data_req_issue.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared op codes, state encoding and widths for the data-memory interface
package mem_if_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_STRB_W = MEM_DATA_W / 8;

   // Bit 3 of the op code distinguishes stores from loads.
   localparam logic [3:0] OP_LB  = 4'd0;
   localparam logic [3:0] OP_LBU = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LW  = 4'd4;
   localparam logic [3:0] OP_LWL = 4'd5;
   localparam logic [3:0] OP_LWR = 4'd6;
   localparam logic [3:0] OP_SB  = 4'd8;
   localparam logic [3:0] OP_SH  = 4'd9;
   localparam logic [3:0] OP_SW  = 4'd10;
   localparam logic [3:0] OP_SWL = 4'd11;
   localparam logic [3:0] OP_SWR = 4'd12;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

endpackage

// File: rtl/store_fmt.sv
// rtl/store_fmt.sv - combinational store lane formatting (byte enables, aligned data, size, low address)
module store_fmt
   import mem_if_pkg::*;
(
   input  logic [3:0]            op,
   input  logic [1:0]            a,
   input  logic [MEM_DATA_W-1:0] rt,
   output logic [MEM_STRB_W-1:0] wstrb,
   output logic [MEM_DATA_W-1:0] wdata,
   output logic [1:0]            size,
   output logic [1:0]            addr_lo
);

   always_comb begin
      wstrb = '0;
      wdata = '0;
      size  = SZ_BYTE;
      case (op)
         OP_SB: begin
            wstrb = 4'b0001 << a;
            wdata = {4{rt[7:0]}};
            size  = SZ_BYTE;
         end
         OP_SH: begin
            wstrb = a[1] ? 4'b1100 : 4'b0011;
            wdata = {2{rt[15:0]}};
            size  = SZ_HALF;
         end
         OP_SW: begin
            wstrb = 4'b1111;
            wdata = rt;
            size  = SZ_WORD;
         end
         // swl writes the high end of rt into the low lanes up to a
         OP_SWL: begin
            wstrb = 4'b1111 >> (2'd3 - a);
            wdata = rt >> {2'd3 - a, 3'b000};
            size  = (a == 2'd0) ? SZ_BYTE : (a == 2'd1) ? SZ_HALF : SZ_WORD;
         end
         OP_SWR: begin
            wstrb = 4'b1111 << a;
            wdata = rt << {a, 3'b000};
            size  = (a == 2'd3) ? SZ_BYTE : (a == 2'd2) ? SZ_HALF : SZ_WORD;
         end
         default: ;
      endcase
   end

   always_comb begin
      addr_lo = 2'd0;
      for (int i = MEM_STRB_W - 1; i >= 0; i--) begin
         if (wstrb[i]) addr_lo = i[1:0];
      end
   end

endmodule

// File: rtl/data_req_issue.sv
// rtl/data_req_issue.sv - EXE-to-data-bus request issuer with one outstanding transaction and flush cancel
module data_req_issue
   import mem_if_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              es_req_valid,
   output logic              es_req_ready,
   input  logic [3:0]        es_op,
   input  logic [ADDR_W-1:0] es_addr,
   input  logic [DATA_W-1:0] es_rt_value,
   input  logic              flush,
   output logic              es_adel,
   output logic              es_ades,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [3:0]        data_wstrb,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata,
   output logic              ms_rdata_valid,
   output logic [DATA_W-1:0] ms_rdata,
   output logic              ms_wr_done
);

   state_e            state_q, state_d;
   logic              cancel_q, cancel_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              wr_done_q, wr_done_d;

   logic [3:0]        fmt_wstrb;
   logic [DATA_W-1:0] fmt_wdata;
   logic [1:0]        fmt_size, fmt_lo;
   logic              is_store, misaligned, accept;
   logic [1:0]        new_size;
   logic [ADDR_W-1:0] new_addr;
   logic [3:0]        new_wstrb;
   logic [DATA_W-1:0] new_wdata;

   store_fmt u_store_fmt (
      .op      (es_op),
      .a       (es_addr[1:0]),
      .rt      (es_rt_value),
      .wstrb   (fmt_wstrb),
      .wdata   (fmt_wdata),
      .size    (fmt_size),
      .addr_lo (fmt_lo)
   );

   assign is_store = es_op[3];

   always_comb begin
      misaligned = 1'b0;
      case (es_op)
         OP_LH, OP_LHU, OP_SH: misaligned = es_addr[0];
         OP_LW, OP_SW:         misaligned = (es_addr[1:0] != 2'b00);
         default:              misaligned = 1'b0;
      endcase
   end

   assign es_adel      = es_req_valid && !is_store && misaligned;
   assign es_ades      = es_req_valid &&  is_store && misaligned;
   assign es_req_ready = (state_q == S_IDLE) ||
                         ((state_q == S_WAIT) && data_data_ok && !cancel_q);
   assign accept       = es_req_valid && es_req_ready && !flush && !misaligned;

   always_comb begin
      new_wstrb = fmt_wstrb;
      new_wdata = fmt_wdata;
      new_size  = fmt_size;
      new_addr  = {es_addr[ADDR_W-1:2], fmt_lo};
      if (!is_store) begin
         new_wstrb = '0;
         new_wdata = '0;
         new_addr  = es_addr;
         case (es_op)
            OP_LB, OP_LBU: new_size = SZ_BYTE;
            OP_LH, OP_LHU: new_size = SZ_HALF;
            OP_LWL, OP_LWR: begin
               new_size = SZ_WORD;
               new_addr = {es_addr[ADDR_W-1:2], 2'b00};
            end
            default:       new_size = SZ_WORD;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      cancel_d  = cancel_q;
      wr_d      = wr_q;
      size_d    = size_q;
      addr_d    = addr_q;
      wstrb_d   = wstrb_q;
      wdata_d   = wdata_q;
      rvalid_d  = 1'b0;
      rdata_d   = rdata_q;
      wr_done_d = 1'b0;
      case (state_q)
         S_REQ: begin
            // addr_ok together with flush still means the bus owes us a data_ok
            if (data_addr_ok) begin
               state_d  = S_WAIT;
               cancel_d = flush;
            end else if (flush) begin
               state_d  = S_IDLE;
            end
         end
         S_WAIT: begin
            if (data_data_ok) begin
               state_d  = S_IDLE;
               cancel_d = 1'b0;
               if (!cancel_q && !flush) begin
                  rvalid_d  = !wr_q;
                  wr_done_d = wr_q;
                  if (!wr_q) rdata_d = data_rdata;
               end
            end else if (flush) begin
               cancel_d = 1'b1;
            end
         end
         default: ;
      endcase
      if (accept) begin
         state_d = S_REQ;
         wr_d    = is_store;
         size_d  = new_size;
         addr_d  = new_addr;
         wstrb_d = new_wstrb;
         wdata_d = new_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cancel_q  <= 1'b0;
         wr_q      <= 1'b0;
         size_q    <= '0;
         addr_q    <= '0;
         wstrb_q   <= '0;
         wdata_q   <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         wr_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cancel_q  <= cancel_d;
         wr_q      <= wr_d;
         size_q    <= size_d;
         addr_q    <= addr_d;
         wstrb_q   <= wstrb_d;
         wdata_q   <= wdata_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         wr_done_q <= wr_done_d;
      end
   end

   assign data_req       = (state_q == S_REQ);
   assign data_wr        = wr_q;
   assign data_size      = size_q;
   assign data_addr      = addr_q;
   assign data_wstrb     = wstrb_q;
   assign data_wdata     = wdata_q;
   assign ms_rdata_valid = rvalid_q;
   assign ms_rdata       = rdata_q;
   assign ms_wr_done     = wr_done_q;

   // A data_ok is only legal while a transaction is outstanding.
   a_no_stray_data_ok: assert property (@(posedge clk) disable iff (reset)
      data_data_ok |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_data_req_issue.sv
// tb/tb_data_req_issue.sv - randomized bench for data_req_issue against a byte-lane reference model
module tb_data_req_issue;
   import mem_if_pkg::*;

   logic        clk;
   logic        reset;
   logic        es_req_valid;
   logic        es_req_ready;
   logic [3:0]  es_op;
   logic [31:0] es_addr;
   logic [31:0] es_rt_value;
   logic        flush;
   logic        es_adel, es_ades;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        ms_rdata_valid;
   logic [31:0] ms_rdata;
   logic        ms_wr_done;

   int tests_run    = 0;
   int tests_failed = 0;

   data_req_issue dut (
      .clk            (clk),
      .reset          (reset),
      .es_req_valid   (es_req_valid),
      .es_req_ready   (es_req_ready),
      .es_op          (es_op),
      .es_addr        (es_addr),
      .es_rt_value    (es_rt_value),
      .flush          (flush),
      .es_adel        (es_adel),
      .es_ades        (es_ades),
      .data_req       (data_req),
      .data_wr        (data_wr),
      .data_size      (data_size),
      .data_addr      (data_addr),
      .data_wstrb     (data_wstrb),
      .data_wdata     (data_wdata),
      .data_addr_ok   (data_addr_ok),
      .data_data_ok   (data_data_ok),
      .data_rdata     (data_rdata),
      .ms_rdata_valid (ms_rdata_valid),
      .ms_rdata       (ms_rdata),
      .ms_wr_done     (ms_wr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Lane view: each bus byte lane i carries rt byte src(i); lanes lo..hi are enabled.
   function automatic void model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                                 output logic mis, output logic [3:0] strb, output logic [31:0] wd,
                                 output logic [1:0] sz, output logic [31:0] ad);
      int a, lo, hi, src;
      a    = int'(addr[1:0]);
      mis  = ((op == OP_LH || op == OP_LHU || op == OP_SH) && (a % 2 == 1)) ||
             ((op == OP_LW || op == OP_SW) && a != 0);
      strb = '0;
      wd   = '0;
      sz   = 2'd0;
      ad   = addr;
      if (!op[3]) begin
         if (op == OP_LWL || op == OP_LWR) begin
            ad = addr & ~32'd3;
            sz = 2'd2;
         end else if (op == OP_LH || op == OP_LHU) sz = 2'd1;
         else if (op == OP_LW) sz = 2'd2;
         return;
      end
      case (op)
         OP_SB:   begin lo = a;     hi = a;      end
         OP_SH:   begin lo = a & 2; hi = lo + 1; end
         OP_SW:   begin lo = 0;     hi = 3;      end
         OP_SWL:  begin lo = 0;     hi = a;      end
         default: begin lo = a;     hi = 3;      end
      endcase
      for (int i = 0; i < 4; i++) begin
         case (op)
            OP_SB:   src = 0;
            OP_SH:   src = i % 2;
            OP_SW:   src = i;
            OP_SWL:  src = i + 3 - a;
            default: src = i - a;
         endcase
         if (i >= lo && i <= hi) strb[i] = 1'b1;
         if (src >= 0 && src <= 3) wd[8*i +: 8] = rt[8*src +: 8];
      end
      sz = (hi - lo >= 2) ? 2'd2 : 2'(hi - lo);
      ad = {addr[31:2], 2'(lo)};
   endfunction

   // fmode: 0 none, 1 flush in REQ instead of addr_ok, 2 flush with addr_ok, 3 flush in first WAIT cycle
   task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input int ao_dly, input int do_dly, input logic [31:0] rd, input int fmode);
      logic mis, st, cancelled;
      logic [3:0] e_strb;
      logic [31:0] e_wd, e_ad;
      logic [1:0] e_sz;
      model(op, addr, rt, mis, e_strb, e_wd, e_sz, e_ad);
      st = op[3];
      if (fmode == 3 && do_dly == 0) do_dly = 1;
      es_req_valid = 1'b1;
      es_op        = op;
      es_addr      = addr;
      es_rt_value  = rt;
      #1;
      check("ready_idle", es_req_ready, 1);
      check("adel", es_adel, mis && !st);
      check("ades", es_ades, mis && st);
      @(posedge clk); #1;
      es_req_valid = 1'b0;
      es_op        = 4'($urandom);
      es_addr      = $urandom;
      es_rt_value  = $urandom;
      if (mis) begin
         check("no_req_on_err", data_req, 0);
         return;
      end
      for (int k = 0; k <= ao_dly; k++) begin
         check("req_held", data_req, 1);
         check("wr", data_wr, st);
         check("size", data_size, e_sz);
         check("addr", data_addr, e_ad);
         check("wstrb", data_wstrb, e_strb);
         if (st) check("wdata", data_wdata, e_wd);
         if (k == ao_dly) begin
            if (fmode == 1) flush = 1'b1;
            else begin
               data_addr_ok = 1'b1;
               flush        = (fmode == 2);
            end
         end
         @(posedge clk); #1;
         data_addr_ok = 1'b0;
         flush        = 1'b0;
      end
      if (fmode == 1) begin
         check("flush_req_drop", data_req, 0);
         check("flush_req_idle", es_req_ready, 1);
         return;
      end
      cancelled = (fmode == 2);
      for (int k = 0; k <= do_dly; k++) begin
         check("wait_no_req", data_req, 0);
         if (k == 0 && fmode == 3) begin
            flush     = 1'b1;
            cancelled = 1'b1;
         end
         if (k == do_dly) begin
            data_data_ok = 1'b1;
            data_rdata   = rd;
            #1;
            check("ready_on_done", es_req_ready, !cancelled);
         end
         @(posedge clk); #1;
         data_data_ok = 1'b0;
         flush        = 1'b0;
         data_rdata   = $urandom;
      end
      check("rvalid", ms_rdata_valid, !st && !cancelled);
      check("wr_done", ms_wr_done, st && !cancelled);
      if (!st && !cancelled) check("rdata", ms_rdata, rd);
      @(posedge clk); #1;
      check("rvalid_once", ms_rdata_valid, 0);
      check("wr_done_once", ms_wr_done, 0);
      check("ready_after", es_req_ready, 1);
   endtask

   logic [3:0] ops [12];

   initial begin
      logic [31:0] ra;
      int r, fm;
      ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
              OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
      reset = 1'b1; es_req_valid = 1'b0; es_op = '0; es_addr = '0; es_rt_value = '0;
      flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", data_req, 0);
      check("rst_wr", data_wr, 0);
      check("rst_size", data_size, 0);
      check("rst_addr", data_addr, 0);
      check("rst_wstrb", data_wstrb, 0);
      check("rst_wdata", data_wdata, 0);
      check("rst_rvalid", ms_rdata_valid, 0);
      check("rst_rdata", ms_rdata, 0);
      check("rst_wr_done", ms_wr_done, 0);
      check("rst_ready", es_req_ready, 1);
      reset = 1'b0;

      run_txn(OP_SB,  32'h1003, 32'h0000_00AB, 0, 1, 32'h0, 0);
      check("sb_wstrb_const", data_wstrb, 4'b1000);
      check("sb_wdata_const", data_wdata, 32'hABAB_ABAB);
      run_txn(OP_SWL, 32'h2001, 32'h1122_3344, 0, 0, 32'h0, 0);
      check("swl_wdata_const", data_wdata, 32'h0000_1122);
      run_txn(OP_SWR, 32'h2002, 32'h1122_3344, 1, 0, 32'h0, 0);
      check("swr_wdata_const", data_wdata, 32'h3344_0000);
      run_txn(OP_LW,  32'h3000, 32'h0, 4, 0, 32'hDEAD_BEEF, 0);
      check("lw_rdata_const", ms_rdata, 32'hDEAD_BEEF);
      run_txn(OP_LH,  32'h3001, 32'h0, 0, 0, 32'h0, 0);
      run_txn(OP_SW,  32'h3002, 32'h5, 0, 0, 32'h0, 0);
      run_txn(OP_LW,  32'h4000, 32'h0, 0, 2, 32'h1234_5678, 3);
      run_txn(OP_LW,  32'h4004, 32'h0, 0, 1, 32'hCAFE_F00D, 0);
      run_txn(OP_SW,  32'h5000, 32'h9, 2, 0, 32'h0, 1);
      run_txn(OP_LBU, 32'h5001, 32'h0, 1, 1, 32'h0BAD_0BAD, 2);
      run_txn(OP_LWL, 32'h5003, 32'h0, 0, 0, 32'h7777_8888, 0);

      // reset in the middle of a request drops it at once
      es_req_valid = 1'b1; es_op = OP_LW; es_addr = 32'h6000;
      @(posedge clk); #1;
      es_req_valid = 1'b0;
      check("mid_req", data_req, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_rst_req", data_req, 0);
      check("mid_rst_ready", es_req_ready, 1);
      check("mid_rst_addr", data_addr, 0);

      for (int n = 0; n < 80; n++) begin
         ra = $urandom;
         if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
         r  = $urandom_range(0, 9);
         fm = (r <= 6) ? 0 : r - 6;
         run_txn(ops[$urandom_range(0, 11)], ra, $urandom, $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom, fm);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
